// File: rtl/fifo_uart_tx.sv
// Drains a registered-read FIFO one word at a time and serialises each word
// onto a UART line: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    output logic             tx,
    output logic             busy,
    output logic             tx_done,
    output logic [15:0]      frames_sent,
    output logic [2:0]       state_dbg
);

    // FIFO handshake: a pop is a one-cycle fifo_rd_en pulse issued only after
    // fifo_empty=0 was seen in IDLE; the popped word is valid on fifo_dout in
    // the following (LOAD) cycle and is captured at the end of that cycle.
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [BIT_W-1:0]   bit_idx, bit_n;
    logic [WIDTH-1:0]   shreg, sh_n;
    logic               par, par_n;
    logic               bit_end;
    logic               tx_n;
    logic               done_n;

    assign state_dbg = state;

    always_comb begin
        state_n = state;
        cnt_n   = '0;
        bit_n   = bit_idx;
        sh_n    = shreg;
        par_n   = par;
        bit_end = (cnt == CNT_W'(CLKS_PER_BIT - 1));
        case (state)
            IDLE:  if (enable && !fifo_empty) state_n = FETCH;
            FETCH: state_n = LOAD;
            LOAD: begin
                sh_n    = fifo_dout;
                par_n   = (^fifo_dout) ^ (PARITY_ODD != 0);
                bit_n   = '0;
                state_n = START;
            end
            START: if (bit_end) state_n = DATA;
            DATA: if (bit_end) begin
                sh_n = shreg >> 1;
                if (bit_idx == BIT_W'(WIDTH - 1)) begin
                    bit_n   = '0;
                    state_n = (PARITY_EN != 0) ? PARITY : STOP;
                end else begin
                    bit_n = bit_idx + 1'b1;
                end
            end
            PARITY: if (bit_end) state_n = STOP;
            STOP: if (bit_end) begin
                if (bit_idx == BIT_W'(STOP_BITS - 1)) begin
                    bit_n   = '0;
                    state_n = IDLE;
                end else begin
                    bit_n = bit_idx + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Baud counter runs only while a bit is on the line and restarts on any state change.
        if (state_n == state && !bit_end && state != IDLE && state != FETCH && state != LOAD)
            cnt_n = cnt + 1'b1;

        // Outputs are registered, so they are derived from the next-cycle view.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = sh_n[0];
            PARITY:  tx_n = par_n;
            default: tx_n = 1'b1;
        endcase
        done_n = (state_n == STOP) && (cnt_n == CNT_W'(CLKS_PER_BIT - 1))
                 && (bit_n == BIT_W'(STOP_BITS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            par         <= 1'b0;
            tx          <= 1'b1;
            fifo_rd_en  <= 1'b0;
            busy        <= 1'b0;
            tx_done     <= 1'b0;
            frames_sent <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_n;
            shreg      <= sh_n;
            par        <= par_n;
            tx         <= tx_n;
            fifo_rd_en <= (state_n == FETCH);
            busy       <= (state_n != IDLE);
            tx_done    <= done_n;
            if (done_n) frames_sent <= frames_sent + 16'd1;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (no parity / even parity + 2 stop /
// odd parity) share one queue-based FIFO model; only one is enabled at a time.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  en = 3'b000;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_dout = 8'h00;
    logic [2:0]  rd, txv, busyv, donev;
    logic [15:0] fs0, fs1, fs2;
    logic [2:0]  st0, st1, st2;

    logic [7:0]  fq[$];
    logic [15:0] exp_fs[3];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable(en[0]), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(rd[0]), .tx(txv[0]), .busy(busyv[0]), .tx_done(donev[0]),
        .frames_sent(fs0), .state_dbg(st0));
    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable(en[1]), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(rd[1]), .tx(txv[1]), .busy(busyv[1]), .tx_done(donev[1]),
        .frames_sent(fs1), .state_dbg(st1));
    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .enable(en[2]), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(rd[2]), .tx(txv[2]), .busy(busyv[2]), .tx_done(donev[2]),
        .frames_sent(fs2), .state_dbg(st2));

    // Registered-read FIFO: a pop presents the word on the next cycle.
    always @(posedge clk) begin
        if ((|rd) && fq.size() > 0) fifo_dout <= fq.pop_front();
        fifo_empty <= (fq.size() == 0);
    end

    function automatic logic [15:0] fs_of(input int s);
        case (s)
            0:       return fs0;
            1:       return fs1;
            default: return fs2;
        endcase
    endfunction

    task automatic push(input logic [7:0] d);
        fq.push_back(d);
    endtask

    task automatic wait_pop(input int s, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!rd[s] && waited < 40);
        total++;
        if (rd[s] !== 1'b1) begin
            bad++;
            $display("FAIL pop_timeout dut%0d: fifo_rd_en=%b after %0d cycles, required 1", s, rd[s], waited);
        end
    endtask

    // Called at the negedge of the FETCH cycle; follows the frame to its last stop cycle.
    task automatic check_frame(input int s, input logic [7:0] d, input int drop_at);
        logic [0:0] exp_q[$];
        logic       po;
        int         nstop, len;
        po    = (s == 2);
        nstop = (s == 1) ? 2 : 1;
        exp_q.push_back(1'b0);
        for (int k = 0; k < 8; k++) exp_q.push_back(d[k]);
        if (s != 0) exp_q.push_back(($countones(d) % 2 == 1) ^ po);
        for (int k = 0; k < nstop; k++) exp_q.push_back(1'b1);
        len = exp_q.size() * CPB;

        @(negedge clk);
        total++;
        if (txv[s] !== 1'b1 || rd[s] !== 1'b0) begin
            bad++;
            $display("FAIL load_cycle dut%0d: tx=%b rd_en=%b, required tx=1 rd_en=0", s, txv[s], rd[s]);
        end
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i == drop_at) en[s] = 1'b0;
            total++;
            if (txv[s] !== exp_q[i / CPB]) begin
                bad++;
                $display("FAIL tx_bit dut%0d data=%h clk=%0d: tx=%b, required %b", s, d, i, txv[s], exp_q[i / CPB]);
            end
            total++;
            if (donev[s] !== (i == len - 1)) begin
                bad++;
                $display("FAIL tx_done dut%0d clk=%0d/%0d: tx_done=%b", s, i, len, donev[s]);
            end
            total++;
            if (rd[s] !== 1'b0 || busyv[s] !== 1'b1) begin
                bad++;
                $display("FAIL frame_ctl dut%0d clk=%0d: rd_en=%b busy=%b, required 0/1", s, i, rd[s], busyv[s]);
            end
        end
        exp_fs[s] = exp_fs[s] + 16'd1;
        total++;
        if (fs_of(s) !== exp_fs[s]) begin
            bad++;
            $display("FAIL frames_sent dut%0d: got %h, required %h", s, fs_of(s), exp_fs[s]);
        end
    endtask

    task automatic send_one(input int s, input logic [7:0] d);
        int w;
        en = 3'b000;
        en[s] = 1'b1;
        push(d);
        wait_pop(s, w);
        check_frame(s, d, -1);
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            total++;
            if (txv[s] !== 1'b1 || rd[s] !== 1'b0 || busyv[s] !== 1'b0 || donev[s] !== 1'b0 || fs_of(s) !== 16'h0) begin
                bad++;
                $display("FAIL reset_state dut%0d: tx=%b rd=%b busy=%b done=%b fs=%h, required 1/0/0/0/0000",
                         s, txv[s], rd[s], busyv[s], donev[s], fs_of(s));
            end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        send_one(0, 8'hA5);
        @(negedge clk);
        total++;
        if (busyv[0] !== 1'b0 || txv[0] !== 1'b1) begin
            bad++;
            $display("FAIL single_idle: busy=%b tx=%b, required 0/1", busyv[0], txv[0]);
        end
    endtask

    task automatic test_parity();
        send_one(1, 8'hA5);
        send_one(2, 8'hA5);
        send_one(1, 8'h07);
        send_one(2, 8'h07);
        en = 3'b000;
    endtask

    task automatic test_back_to_back();
        logic [7:0] words[3];
        int w, extra;
        words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF;
        en = 3'b001;
        for (int k = 0; k < 3; k++) push(words[k]);
        for (int k = 0; k < 3; k++) begin
            wait_pop(0, w);
            if (k > 0) begin
                total++;
                if (w !== 2) begin
                    bad++;
                    $display("FAIL b2b_gap frame%0d: pop %0d cycles after tx_done, required 2", k, w);
                end
            end
            check_frame(0, words[k], -1);
        end
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rd[0] || busyv[0]) extra++;
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("FAIL b2b_drained: %0d cycles with rd_en/busy high, required 0", extra);
        end
    endtask

    task automatic test_empty_gating();
        int n_rd, n_tx, n_busy;
        n_rd = 0; n_tx = 0; n_busy = 0;
        en = 3'b111;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (|rd) n_rd++;
            if (txv !== 3'b111) n_tx++;
            if (|busyv) n_busy++;
        end
        en = 3'b000;
        total++;
        if (n_rd !== 0) begin bad++; $display("FAIL empty_rd: %0d pop cycles, required 0", n_rd); end
        total++;
        if (n_tx !== 0) begin bad++; $display("FAIL empty_tx: %0d non-mark cycles, required 0", n_tx); end
        total++;
        if (n_busy !== 0) begin bad++; $display("FAIL empty_busy: %0d busy cycles, required 0", n_busy); end
    endtask

    task automatic test_enable_gating();
        logic [7:0] d;
        int n_rd, w;
        d = 8'($urandom_range(0, 255));
        en = 3'b000;
        push(d);
        n_rd = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (|rd) n_rd++;
        end
        total++;
        if (n_rd !== 0 || fq.size() !== 1) begin
            bad++;
            $display("FAIL enable_low: pops=%0d fifo_level=%0d, required 0/1", n_rd, fq.size());
        end
        en[0] = 1'b1;
        wait_pop(0, w);
        check_frame(0, d, -1);
    endtask

    task automatic test_enable_drop();
        logic [7:0] d1;
        int n_rd, w;
        d1 = 8'($urandom_range(0, 255));
        en = 3'b001;
        push(d1);
        push(8'($urandom_range(0, 255)));
        wait_pop(0, w);
        check_frame(0, d1, 20);
        n_rd = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (|rd) n_rd++;
        end
        total++;
        if (n_rd !== 0 || fq.size() !== 1) begin
            bad++;
            $display("FAIL enable_drop: pops=%0d fifo_level=%0d, required 0/1", n_rd, fq.size());
        end
    endtask

    // One word is still queued from the previous test; it is popped and then aborted.
    task automatic test_reset_mid_frame();
        logic [7:0] d;
        int w;
        d = 8'($urandom_range(0, 255));
        push(d);
        en = 3'b001;
        wait_pop(0, w);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (txv[0] !== 1'b1 || busyv[0] !== 1'b0 || fs0 !== 16'h0 || rd[0] !== 1'b0) begin
            bad++;
            $display("FAIL reset_abort: tx=%b busy=%b fs=%h rd=%b, required 1/0/0000/0", txv[0], busyv[0], fs0, rd[0]);
        end
        for (int s = 0; s < 3; s++) exp_fs[s] = 16'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_pop(0, w);
        check_frame(0, d, -1);
        total++;
        if (fq.size() !== 0) begin
            bad++;
            $display("FAIL reset_fifo_level: %0d words left, required 0", fq.size());
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 3; s++)
            for (int k = 0; k < 3; k++)
                send_one(s, 8'($urandom));
        en = 3'b000;
    endtask

    task automatic test_wrap();
        en = 3'b000;
        @(negedge clk);
        force u_dut0.frames_sent = 16'hFFFF;
        @(negedge clk);
        release u_dut0.frames_sent;
        exp_fs[0] = 16'hFFFF;
        send_one(0, 8'h3C);
        en = 3'b000;
    endtask

    initial begin
        for (int s = 0; s < 3; s++) exp_fs[s] = 16'h0;
        repeat (3) @(negedge clk);
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_empty_gating();
        test_enable_gating();
        test_enable_drop();
        test_reset_mid_frame();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
